// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants for the front end: reset fetch address, nop encoding,
// and the default datapath width.
package fetch_queue_pkg;

    localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam int          CPU_DATA_W = 32;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping PTR_W-bit pointer for the fetch queue; clr beats inc, and the
// wrap from DEPTH-1 to 0 comes from the natural PTR_W-bit overflow.
module fq_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: circular FIFO of (pc, instr) pairs between the PC
// stage and decode, with a flush that drops everything on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; ready/valid here depend only on registered count, never on the
    // partner's signal, and a flush on that edge cancels both transfers.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    fq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    fq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Storage is not reset; only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : INSTR_NOP;

    // Upstream must hold a stalled pair until it is accepted (a redirect may change it).
    a_hold_stalled_pair: assert property (
        @(posedge clk) disable iff (!reset)
        (in_valid && !in_ready && !flush) |=> ($stable(in_pc) && $stable(in_instr))
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int DW    = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_instr;
    logic          out_ready;
    logic          flush;
    logic [PTR_W:0] count;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of {pc, instr} currently held.
    logic [63:0] exp_q[$];
    bit          m_ready;
    bit          m_valid;
    int          m_size;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            m_ready = (exp_q.size() != DEPTH);
            m_valid = (exp_q.size() != 0);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && out_ready) void'(exp_q.pop_front());
                if (m_ready && in_valid)  exp_q.push_back({in_pc, in_instr});
            end
        end
    end

    always @(negedge clk) begin
        m_size  = exp_q.size();
        m_pc    = (m_size != 0) ? exp_q[0][63:32] : 32'h0;
        m_instr = (m_size != 0) ? exp_q[0][31:0]  : INSTR_NOP;
        check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_size != 0});
        check("cyc_in_ready",  {31'b0, in_ready},  {31'b0, m_size != DEPTH});
        check("cyc_count",     {29'b0, count},     m_size);
        check("cyc_out_pc",    out_pc,    m_pc);
        check("cyc_out_instr", out_instr, m_instr);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = PC_DEFAULT;
        in_instr  = INSTR_NOP;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_count",     {29'b0, count},     32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc",    out_pc,    32'h0);
        #9 reset = 1'b1;
        step();

        // single pass
        push(32'h0000_3000, 32'h3C01_0001);
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_pc",    out_pc,    32'h0000_3000);
        check("single_instr", out_instr, 32'h3C01_0001);
        check("single_count", {29'b0, count}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drain_count", {29'b0, count}, 32'd0);
        check("single_drain_valid", {31'b0, out_valid}, 32'd0);

        // fill to full; a fifth push is held off
        for (int k = 0; k < 4; k++) push(32'h0000_3000 + 4 * k, 32'h2400_0000 + k);
        check("full_count", {29'b0, count}, 32'd4);
        check("full_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_pc    = 32'h0000_3010;
        in_instr = 32'h2400_0004;
        step();
        step();
        in_valid = 1'b0;
        check("full_ignore_count", {29'b0, count}, 32'd4);
        check("full_head_pc", out_pc, 32'h0000_3000);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_pc",    out_pc,    32'h0000_3000 + 4 * k);
            check("drain_instr", out_instr, 32'h2400_0000 + k);
            step();
        end
        out_ready = 1'b0;
        check("drain_empty_count", {29'b0, count}, 32'd0);

        // simultaneous push/pop at count=2, across pointer wrap
        push(32'h0000_3000, 32'h2000_0000);
        push(32'h0000_3004, 32'h2000_0001);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc    = 32'h0000_3000 + 4 * (k + 2);
            in_instr = 32'h2000_0000 + k + 2;
            check("pp_count", {29'b0, count}, 32'd2);
            check("pp_pc",    out_pc, 32'h0000_3000 + 4 * k);
            step();
        end
        in_valid = 1'b0;
        check("pp_after_count", {29'b0, count}, 32'd2);
        check("pp_after_pc",    out_pc, 32'h0000_3028);
        step();
        step();
        out_ready = 1'b0;
        check("pp_drained", {29'b0, count}, 32'd0);

        // flush beats a simultaneous push and pop
        push(32'h0000_3100, 32'h1111_0000);
        push(32'h0000_3104, 32'h1111_0001);
        push(32'h0000_3108, 32'h1111_0002);
        check("flush_pre_count", {29'b0, count}, 32'd3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_310C;
        in_instr  = 32'h1111_0003;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_count", {29'b0, count}, 32'd0);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        step();
        step();
        check("flush_no_ghost", {31'b0, out_valid}, 32'd0);
        push(32'h0000_3200, 32'h2222_0000);
        check("flush_restart_pc", out_pc, 32'h0000_3200);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // pop while full: in_ready rises only on the following cycle
        for (int k = 0; k < 4; k++) push(32'h0000_3300 + 4 * k, 32'h3333_0000 + k);
        out_ready = 1'b1;
        check("fp_ready_same_cycle", {31'b0, in_ready}, 32'd0);
        step();
        out_ready = 1'b0;
        check("fp_count",  {29'b0, count}, 32'd3);
        check("fp_ready",  {31'b0, in_ready}, 32'd1);
        check("fp_head",   out_pc, 32'h0000_3304);

        // asynchronous reset mid-operation
        #2 reset = 1'b0;
        #1;
        check("midrst_count", {29'b0, count}, 32'd0);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_pc",    out_pc, 32'h0);
        #3 reset = 1'b1;
        step();
        push(32'h0000_3400, 32'h4444_0000);
        check("postrst_pc", out_pc, 32'h0000_3400);
        check("postrst_count", {29'b0, count}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
